// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// rtl/bs_gnrtr_n_rbtr_pkg.sv - shared types and constants for the bus generator/arbiter
package bs_gnrtr_n_rbtr_pkg;

  localparam int ID_W = 8;

  typedef enum logic {
    ARB     = 1'b0,
    DELIVER = 1'b1
  } bus_state_e;

endpackage

// File: rtl/bs_gnrtr_n_rbtr_if.sv
// rtl/bs_gnrtr_n_rbtr_if.sv - device-FIFO side signals of all buses
interface bs_gnrtr_n_rbtr_if #(
  parameter int bits    = 1,
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);

  logic [bits-1:0][drvrs-1:0]              pndng;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [bits-1:0][drvrs-1:0]              pop;
  logic [bits-1:0][drvrs-1:0]              push;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

  modport master (
    output pndng, D_pop,
    input  pop, push, D_push
  );

  modport slave (
    input  pndng, D_pop,
    output pop, push, D_push
  );

endinterface

// File: rtl/bs_gnrtr_n_rbtr_bus_channel.sv
// rtl/bs_gnrtr_n_rbtr_bus_channel.sv - one bus: round-robin arbiter, ARB/DELIVER FSM, destination decode
module bus_channel
  import bs_gnrtr_n_rbtr_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   d_push
);

  localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

  bus_state_e         state;
  bus_state_e         state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   src;
  logic               grant_vld;
  logic [pckg_sz-1:0] pkt;
  logic [ID_W-1:0]    dest;
  int                 scan_idx;

  // First pending device at or after ptr, wrapping around.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    for (int j = 0; j < drvrs; j++) begin
      scan_idx = (int'(ptr) + j) % drvrs;
      if (!grant_vld && pndng[IDX_W'(scan_idx)]) begin
        grant     = IDX_W'(scan_idx);
        grant_vld = 1'b1;
      end
    end
  end

  assign dest = pkt[pckg_sz-1 -: ID_W];

  always_comb begin
    state_nxt = state;
    pop       = '0;
    push      = '0;
    case (state)
      ARB: begin
        if (grant_vld) begin
          pop[grant] = 1'b1;
          state_nxt  = DELIVER;
        end
      end
      DELIVER: begin
        state_nxt = ARB;
        if (dest == broadcast) begin
          push      = '1;
          push[src] = 1'b0;
        end else if (int'(dest) < drvrs) begin
          push[dest[IDX_W-1:0]] = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
    // pop is combinational from pndng, so reset must silence it directly
    if (reset) begin
      pop = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB;
      ptr   <= '0;
      src   <= '0;
      pkt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && grant_vld) begin
        pkt <= d_pop[grant];
        src <= grant;
        ptr <= (int'(grant) == drvrs - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  assign d_push = {drvrs{pkt}};

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// rtl/bs_gnrtr_n_rbtr.sv - top: one independent bus_channel per bus
module bs_gnrtr_n_rbtr
  import bs_gnrtr_n_rbtr_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  bs_gnrtr_n_rbtr_if.slave   bus
);

  for (genvar b = 0; b < bits; b++) begin : g_bus
    bus_channel #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .pndng  (bus.pndng[b]),
      .d_pop  (bus.D_pop[b]),
      .pop    (bus.pop[b]),
      .push   (bus.push[b]),
      .d_push (bus.D_push[b])
    );
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb/tb_bs_gnrtr_n_rbtr.sv - self-checking bench with a transaction-level reference model
module tb_bs_gnrtr_n_rbtr;

  localparam int         BITS  = 2;
  localparam int         DRVRS = 4;
  localparam int         PW    = 16;
  localparam logic [7:0] BCAST = 8'hFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bs_gnrtr_n_rbtr_if #(.bits(BITS), .drvrs(DRVRS), .pckg_sz(PW)) bus_if ();

  bs_gnrtr_n_rbtr #(
    .bits      (BITS),
    .drvrs     (DRVRS),
    .pckg_sz   (PW),
    .broadcast (BCAST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int tests = 0;
  int fails = 0;

  // Model: each bus either idle or holding one in-flight packet.
  int          nxt  [BITS];
  bit          busy [BITS];
  logic [PW-1:0] pkt [BITS];
  int          src  [BITS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int b);
    for (int j = 0; j < DRVRS; j++) begin
      if (bus_if.pndng[b][(nxt[b] + j) % DRVRS]) return (nxt[b] + j) % DRVRS;
    end
    return -1;
  endfunction

  function automatic logic [DRVRS-1:0] exp_push(input int b);
    logic [7:0] d;
    logic [DRVRS-1:0] m;
    m = '0;
    if (!busy[b]) return m;
    d = pkt[b][PW-1 -: 8];
    if (d == BCAST) begin
      for (int k = 0; k < DRVRS; k++) if (k != src[b]) m[k] = 1'b1;
    end else if (int'(d) < DRVRS) begin
      m[d] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < BITS; b++) begin
      nxt[b] = 0; busy[b] = 0; pkt[b] = '0; src[b] = 0;
    end
  endtask

  task automatic sample(input string tag);
    int g;
    logic [DRVRS-1:0] ep;
    @(negedge clk);
    for (int b = 0; b < BITS; b++) begin
      ep = '0;
      if (!busy[b]) begin
        g = pick(b);
        if (g >= 0) ep[g] = 1'b1;
      end
      check($sformatf("%s.pop%0d", tag, b), 32'(bus_if.pop[b]), 32'(ep));
      check($sformatf("%s.push%0d", tag, b), 32'(bus_if.push[b]), 32'(exp_push(b)));
      if (busy[b]) begin
        for (int k = 0; k < DRVRS; k++)
          check($sformatf("%s.dpush%0d_%0d", tag, b, k), 32'(bus_if.D_push[b][k]), 32'(pkt[b]));
      end
    end
  endtask

  task automatic advance();
    int g;
    for (int b = 0; b < BITS; b++) begin
      if (busy[b]) begin
        busy[b] = 0;
      end else begin
        g = pick(b);
        if (g >= 0) begin
          busy[b] = 1;
          pkt[b]  = bus_if.D_pop[b][g];
          src[b]  = g;
          nxt[b]  = (g + 1) % DRVRS;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.pndng = '1;
    bus_if.D_pop = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst.pop", 32'(bus_if.pop), 32'h0);
    check("rst.push", 32'(bus_if.push), 32'h0);
    check("rst.dpush", 32'(bus_if.D_push[0][0]), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_if.pndng = '0;
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [7:0] d;
    case ($urandom_range(0, 5))
      4:       d = BCAST;
      5:       d = 8'($urandom_range(DRVRS, 254));
      default: d = 8'($urandom_range(0, DRVRS - 1));
    endcase
    return {d, 8'($urandom)};
  endfunction

  initial begin
    bus_if.pndng = '0;
    bus_if.D_pop = '0;
    do_reset();

    // Unicast to device 2
    bus_if.pndng[0][0] = 1'b1;
    bus_if.D_pop[0][0] = 16'h02AB;
    sample("uni0");
    check("uni.pop", 32'(bus_if.pop[0]), 32'h1);
    advance();
    bus_if.pndng = '0;
    sample("uni1");
    check("uni.push", 32'(bus_if.push[0]), 32'h4);
    check("uni.data", 32'(bus_if.D_push[0][2]), 32'h02AB);
    advance();

    // Broadcast from device 1
    bus_if.pndng[0][1] = 1'b1;
    bus_if.D_pop[0][1] = 16'hFF55;
    sample("bc0");
    check("bc.pop", 32'(bus_if.pop[0]), 32'h2);
    advance();
    bus_if.pndng = '0;
    sample("bc1");
    check("bc.push", 32'(bus_if.push[0]), 32'hD);
    check("bc.data", 32'(bus_if.D_push[0][3]), 32'hFF55);
    advance();

    // Fairness: all pending, grants 0,1,2,3,0 every other cycle
    do_reset();
    for (int d = 0; d < DRVRS; d++) bus_if.D_pop[0][d] = {8'(d), 8'h10 + 8'(d)};
    bus_if.pndng[0] = '1;
    for (int c = 0; c < 10; c++) begin
      sample($sformatf("fair%0d", c));
      check($sformatf("fair.pop%0d", c), 32'(bus_if.pop[0]),
            (c % 2 == 0) ? (32'h1 << ((c / 2) % DRVRS)) : 32'h0);
      advance();
    end
    bus_if.pndng = '0;

    // Invalid destination dropped, bus back in ARB afterwards
    bus_if.pndng[0][3] = 1'b1;
    bus_if.D_pop[0][3] = 16'h07CD;
    sample("inv0");
    check("inv.pop", 32'(bus_if.pop[0]), 32'h8);
    advance();
    sample("inv1");
    check("inv.push", 32'(bus_if.push[0]), 32'h0);
    check("inv.nopop", 32'(bus_if.pop[0]), 32'h0);
    advance();
    sample("inv2");
    check("inv.rearb", 32'(bus_if.pop[0]), 32'h8);
    advance();
    bus_if.pndng = '0;
    sample("inv3");
    advance();

    // Reset while delivering
    do_reset();
    bus_if.pndng[0][2] = 1'b1;
    bus_if.D_pop[0][2] = 16'h01EE;
    sample("rmid0");
    check("rmid.pop", 32'(bus_if.pop[0]), 32'h4);
    advance();
    reset = 1'b1;
    model_reset();
    #1;
    check("rmid.push", 32'(bus_if.push[0]), 32'h0);
    check("rmid.dpush", 32'(bus_if.D_push[0][1]), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_if.pndng[0] = '1;
    sample("rmid1");
    check("rmid.grant0", 32'(bus_if.pop[0]), 32'h1);
    advance();
    bus_if.pndng = '0;
    sample("rmid2");
    advance();

    // Randomized traffic on both buses
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < BITS; b++) begin
        bus_if.pndng[b] = DRVRS'($urandom);
        for (int d = 0; d < DRVRS; d++) bus_if.D_pop[b][d] = rand_pkt();
      end
      sample($sformatf("rnd%0d", c));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
